// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: program memory read port plus the instruction
// valid/ready handshake and jump redirect toward the control unit.
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int INSTRUCTION_WIDTH = 16
);
    logic [INSTRUCTION_WIDTH-1:0] MEM_DATA_IN;
    logic [ADDR_WIDTH-1:0]        MEM_ADDR_OUT;
    logic                         MEM_RD_EN;
    logic [DATA_WIDTH-1:0]        INSTR_OUT;
    logic [DATA_WIDTH-1:0]        ARG_OUT;
    logic [ADDR_WIDTH-1:0]        PC_OUT;
    logic                         INSTR_VALID;
    logic                         INSTR_READY;
    logic                         JUMP_EN;
    logic [ADDR_WIDTH-1:0]        PC_JUMP_IN;

    // Fetch unit side
    modport master (
        input  MEM_DATA_IN, INSTR_READY, JUMP_EN, PC_JUMP_IN,
        output MEM_ADDR_OUT, MEM_RD_EN, INSTR_OUT, ARG_OUT, PC_OUT, INSTR_VALID
    );

    // Memory / control unit side
    modport slave (
        output MEM_DATA_IN, INSTR_READY, JUMP_EN, PC_JUMP_IN,
        input  MEM_ADDR_OUT, MEM_RD_EN, INSTR_OUT, ARG_OUT, PC_OUT, INSTR_VALID
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential reads to a synchronous program
// memory, buffers returned words with their PC in a small prefetch FIFO and
// presents opcode/argument pairs in order. A jump flushes the FIFO, drops
// the read issued in the jump cycle and restarts fetching at the target.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH        = 8,
    parameter int                    ADDR_WIDTH        = 12,
    parameter int                    INSTRUCTION_WIDTH = 16,
    parameter int                    DEPTH             = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR        = '0
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = PTR_W + 2;

    localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

    generate
        if (INSTRUCTION_WIDTH != 2 * DATA_WIDTH) begin : g_bad_width
            $error("INSTRUCTION_WIDTH must equal 2*DATA_WIDTH");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        fetch_pc;
    logic [ADDR_WIDTH-1:0]        inflight_pc;
    logic                         inflight;

    logic [INSTRUCTION_WIDTH-1:0] fifo_word [DEPTH];
    logic [ADDR_WIDTH-1:0]        fifo_pc   [DEPTH];
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [CNT_W-1:0]             count;

    logic [OCC_W-1:0]             occupancy;
    logic                         issue;
    logic                         push;
    logic                         pop;
    logic                         fifo_valid;
    logic [INSTRUCTION_WIDTH-1:0] head_word;

    // Issue/push/pop decisions. Occupancy counts the outstanding read but
    // not a same-cycle pop, so the FIFO can never be overrun by a return.
    // Returns landing in IDLE or REDIRECT, or on a jump edge, belong to a
    // stream that has been abandoned and are dropped.
    always_comb begin
        occupancy  = OCC_W'(count) + OCC_W'(inflight);
        issue      = (state != IDLE) && (occupancy < OCC_W'(DEPTH));
        fifo_valid = (count != '0);
        push       = inflight && (state == RUN) && !bus.JUMP_EN;
        pop        = fifo_valid && bus.INSTR_READY && !bus.JUMP_EN;
        head_word  = fifo_word[rd_ptr];
    end

    assign bus.MEM_RD_EN    = issue;
    assign bus.MEM_ADDR_OUT = issue ? fetch_pc : '0;
    assign bus.INSTR_VALID  = fifo_valid;
    assign bus.INSTR_OUT    = fifo_valid ? head_word[INSTRUCTION_WIDTH-1:DATA_WIDTH] : '0;
    assign bus.ARG_OUT      = fifo_valid ? head_word[DATA_WIDTH-1:0] : '0;
    assign bus.PC_OUT       = fifo_valid ? fifo_pc[rd_ptr] : '0;

    // Sequencer: one dead cycle after reset, a one-cycle redirect per jump
    // (a jump during redirect simply restarts it).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     state <= RUN;
                RUN:      state <= bus.JUMP_EN ? REDIRECT : RUN;
                REDIRECT: state <= bus.JUMP_EN ? REDIRECT : RUN;
                default:  state <= IDLE;
            endcase
        end
    end

    // Fetch address and the single outstanding-read tracker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (bus.JUMP_EN)
                fetch_pc <= bus.PC_JUMP_IN;
            else if (issue)
                fetch_pc <= fetch_pc + PC_ONE;
            inflight    <= issue;
            inflight_pc <= fetch_pc;
        end
    end

    // FIFO pointers and occupancy; a jump empties the FIFO outright.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.JUMP_EN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the valid-gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= bus.MEM_DATA_IN;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: synchronous memory model, directed
// timing checks, then randomized ready/jump/reset traffic. The expected
// instruction stream is program order from the last restart point.
module tb_instruction_fetch_unit;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int IW = 16;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] word;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bus ();

    instruction_fetch_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW),
        .DEPTH(4), .RESET_ADDR(12'h000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [IW-1:0] mem [4096];
    exp_t          q[$];
    logic [AW-1:0] next_pc;
    int            checks = 0;
    int            errors = 0;
    int            issued = 0;

    // Synchronous program memory: data the cycle after the strobe
    always @(posedge clk) begin
        if (bus.MEM_RD_EN) bus.MEM_DATA_IN <= mem[bus.MEM_ADDR_OUT];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keep the expected program-order stream topped up
    task automatic feed();
        while (q.size() < 8) begin
            q.push_back('{pc: next_pc, word: mem[next_pc]});
            next_pc = next_pc + 12'h001;
        end
    endtask

    task automatic restart(input logic [AW-1:0] start);
        q.delete();
        next_pc = start;
        feed();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        feed();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, bus.MEM_RD_EN, 0);
        chk({tag, "_addr"},  bus.MEM_ADDR_OUT, 0);
        chk({tag, "_valid"}, bus.INSTR_VALID, 0);
        chk({tag, "_instr"}, bus.INSTR_OUT, 0);
        chk({tag, "_arg"},   bus.ARG_OUT, 0);
        chk({tag, "_pc"},    bus.PC_OUT, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted instruction and checks
    // that a stalled head stays put.
    initial begin
        logic          hold;
        logic [DW-1:0] h_instr, h_arg;
        logic [AW-1:0] h_pc;
        exp_t          e;
        hold = 1'b0;
        h_instr = '0; h_arg = '0; h_pc = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (bus.MEM_RD_EN) issued++;
                if (hold) begin
                    chk("hold_valid", bus.INSTR_VALID, 1);
                    chk("hold_instr", bus.INSTR_OUT, h_instr);
                    chk("hold_arg",   bus.ARG_OUT, h_arg);
                    chk("hold_pc",    bus.PC_OUT, h_pc);
                end
                if (bus.INSTR_VALID && bus.INSTR_READY && !bus.JUMP_EN) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_empty: got pc %0h expected no instruction", bus.PC_OUT);
                    end else begin
                        e = q.pop_front();
                        chk("pop_pc",    bus.PC_OUT, e.pc);
                        chk("pop_instr", bus.INSTR_OUT, e.word[IW-1:DW]);
                        chk("pop_arg",   bus.ARG_OUT, e.word[DW-1:0]);
                    end
                end
                hold    = bus.INSTR_VALID && !bus.INSTR_READY && !bus.JUMP_EN;
                h_instr = bus.INSTR_OUT;
                h_arg   = bus.ARG_OUT;
                h_pc    = bus.PC_OUT;
            end
        end
    end

    // Stimulus
    initial begin
        int            base;
        logic [AW-1:0] prev_addr;
        logic          prev_ok, saw_wrap;
        logic [AW-1:0] tgt;
        int            r;

        bus.INSTR_READY = 1'b0;
        bus.JUMP_EN     = 1'b0;
        bus.PC_JUMP_IN  = '0;
        for (int i = 0; i < 4096; i++) mem[i] = IW'($urandom);
        mem[0] = 16'hA103;
        restart(12'h000);

        // Reset state and first-word latency
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        base  = issued;
        reset = 1'b1;
        #1;
        chk("idle_rd_en", bus.MEM_RD_EN, 0);
        @(posedge clk); #1;
        chk("c1_rd_en", bus.MEM_RD_EN, 1);
        chk("c1_addr",  bus.MEM_ADDR_OUT, 12'h000);
        chk("c1_valid", bus.INSTR_VALID, 0);
        @(posedge clk); #1;
        chk("c2_valid", bus.INSTR_VALID, 0);
        @(posedge clk); #1;
        chk("c3_valid", bus.INSTR_VALID, 1);
        chk("c3_instr", bus.INSTR_OUT, 8'hA1);
        chk("c3_arg",   bus.ARG_OUT, 8'h03);
        chk("c3_pc",    bus.PC_OUT, 12'h000);

        // Backpressure: exactly DEPTH reads while stalled, head stable
        repeat (10) tick();
        chk("stall_reads", issued - base, 4);
        chk("stall_rd_en", bus.MEM_RD_EN, 0);
        chk("stall_pc",    bus.PC_OUT, 12'h000);

        // Release: one instruction per cycle with no gaps
        bus.INSTR_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stream_valid", bus.INSTR_VALID, 1);
        end

        // Jump with a full FIFO held
        bus.INSTR_READY = 1'b0;
        repeat (6) tick();
        bus.JUMP_EN    = 1'b1;
        bus.PC_JUMP_IN = 12'h200;
        restart(12'h200);
        tick();
        bus.JUMP_EN = 1'b0;
        chk("jmp_valid0", bus.INSTR_VALID, 0);
        chk("jmp_rd_en",  bus.MEM_RD_EN, 1);
        chk("jmp_addr",   bus.MEM_ADDR_OUT, 12'h200);
        tick();
        chk("jmp_valid1", bus.INSTR_VALID, 0);
        tick();
        chk("jmp_valid2", bus.INSTR_VALID, 1);
        chk("jmp_pc",     bus.PC_OUT, 12'h200);
        chk("jmp_instr",  bus.INSTR_OUT, mem[12'h200][IW-1:DW]);

        // Address wrap at the top of the program space
        bus.INSTR_READY = 1'b1;
        bus.JUMP_EN     = 1'b1;
        bus.PC_JUMP_IN  = 12'hFFE;
        restart(12'hFFE);
        tick();
        bus.JUMP_EN = 1'b0;
        prev_ok = 1'b0; saw_wrap = 1'b0; prev_addr = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus.MEM_RD_EN) begin
                if (prev_ok && prev_addr == 12'hFFF && bus.MEM_ADDR_OUT == 12'h000) saw_wrap = 1'b1;
                prev_addr = bus.MEM_ADDR_OUT;
                prev_ok   = 1'b1;
            end
            tick();
        end
        chk("addr_wrap", saw_wrap, 1);

        // Asynchronous reset mid-stream with a read outstanding
        repeat (3) tick();
        chk("pre_reset_rd_en", bus.MEM_RD_EN, 1);
        #2;
        reset = 1'b0;
        restart(12'h000);
        #1;
        chk_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_restart_valid", bus.INSTR_VALID, 1);
        chk("rst_restart_pc",    bus.PC_OUT, 12'h000);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.INSTR_READY = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 199);
            if (r < 10) begin
                tgt = AW'($urandom);
                if ($urandom_range(0, 3) == 0) tgt = 12'hFFC | AW'($urandom_range(0, 3));
                bus.JUMP_EN    = 1'b1;
                bus.PC_JUMP_IN = tgt;
                restart(tgt);
                tick();
            end else if (r == 199) begin
                bus.JUMP_EN = 1'b0;
                reset = 1'b0;
                restart(12'h000);
                #1;
                chk("rnd_reset_valid", bus.INSTR_VALID, 0);
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
                tick();
            end else begin
                bus.JUMP_EN = 1'b0;
                tick();
            end
        end
        bus.JUMP_EN = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
